// File: rtl/matrix_reg_loader.sv
// Keypad matrix loader: stages nine 9-bit digits, commits them to a four-slot
// 3x3 matrix bank, and issues two bank slots as operands to a downstream ALU.
module matrix_reg_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  keycode,
    input  logic        store_dig,
    input  logic        enter,
    input  logic        write_en,
    input  logic [1:0]  dest_sel,
    input  logic [1:0]  src_a_sel,
    input  logic [1:0]  src_b_sel,
    input  logic        op_req,
    input  logic        op_ack,
    output logic [3:0]  elem_idx,
    output logic        stage_full,
    output logic        err,
    output logic [80:0] mat_a,
    output logic [80:0] mat_b,
    output logic        op_valid,
    output logic [3:0]  reg_valid
);

    typedef enum logic [1:0] {COLLECT, FULL, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  elem_idx_q, elem_idx_d;
    logic [80:0] staging_q, staging_d;
    logic [80:0] bank_q [4];
    logic [80:0] bank_d [4];
    logic [1:0]  dest_q, dest_d;
    logic [3:0]  reg_valid_q, reg_valid_d;
    logic [80:0] mat_a_q, mat_a_d;
    logic [80:0] mat_b_q, mat_b_d;
    logic        op_valid_q, op_valid_d;
    logic        err_q, err_d;
    logic        wr_enter;
    logic        loader_err;
    logic        issue_err;

    always_comb begin
        state_d     = state_q;
        elem_idx_d  = elem_idx_q;
        staging_d   = staging_q;
        bank_d      = bank_q;
        dest_d      = dest_q;
        reg_valid_d = reg_valid_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        op_valid_d  = op_valid_q;
        loader_err  = 1'b0;
        issue_err   = 1'b0;
        wr_enter    = enter & write_en;

        case (state_q)
            COLLECT: begin
                // A premature commit aborts the partial matrix; it also wins over a same-cycle digit.
                if (wr_enter) begin
                    loader_err = 1'b1;
                    elem_idx_d = 4'd0;
                    staging_d  = '0;
                end else if (store_dig) begin
                    for (int i = 0; i < 9; i++) begin
                        if (elem_idx_q == 4'(i)) staging_d[9*i +: 9] = keycode;
                    end
                    elem_idx_d = elem_idx_q + 4'd1;
                    if (elem_idx_q == 4'd8) state_d = FULL;
                end
            end
            FULL: begin
                if (store_dig) loader_err = 1'b1;
                if (wr_enter) begin
                    dest_d  = dest_sel;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bank_d[dest_q]      = staging_q;
                reg_valid_d[dest_q] = 1'b1;
                elem_idx_d          = 4'd0;
                state_d             = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        // Issue reads the registered bank and flags, so a same-edge commit is not yet visible.
        if (!op_valid_q) begin
            if (op_req) begin
                if (reg_valid_q[src_a_sel] && reg_valid_q[src_b_sel]) begin
                    mat_a_d    = bank_q[src_a_sel];
                    mat_b_d    = bank_q[src_b_sel];
                    op_valid_d = 1'b1;
                end else begin
                    issue_err = 1'b1;
                end
            end
        end else if (op_ack) begin
            op_valid_d = 1'b0;
        end

        err_d = loader_err | issue_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            elem_idx_q  <= 4'd0;
            staging_q   <= '0;
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
            dest_q      <= 2'd0;
            reg_valid_q <= 4'd0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            op_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_idx_q  <= elem_idx_d;
            staging_q   <= staging_d;
            bank_q      <= bank_d;
            dest_q      <= dest_d;
            reg_valid_q <= reg_valid_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
            op_valid_q  <= op_valid_d;
            err_q       <= err_d;
        end
    end

    assign elem_idx   = elem_idx_q;
    assign stage_full = (elem_idx_q == 4'd9);
    assign err        = err_q;
    assign mat_a      = mat_a_q;
    assign mat_b      = mat_b_q;
    assign op_valid   = op_valid_q;
    assign reg_valid  = reg_valid_q;

endmodule

// File: tb/tb_matrix_reg_loader.sv
// Bench for matrix_reg_loader: directed scenarios plus random traffic against
// a queue-based model of staging, bank and operand issue.
module tb_matrix_reg_loader;

    logic        clk = 1'b0;
    logic        rst, store_dig, enter, write_en, op_req, op_ack;
    logic [8:0]  keycode;
    logic [1:0]  dest_sel, src_a_sel, src_b_sel;
    logic [3:0]  elem_idx, reg_valid;
    logic        stage_full, err, op_valid;
    logic [80:0] mat_a, mat_b;

    int checks = 0;
    int errors = 0;

    // model state
    int          m_stg[$];
    bit          m_commit_pend;
    int          m_dest;
    logic [80:0] m_bank [4];
    bit   [3:0]  m_valid;
    logic [80:0] m_a, m_b;
    bit          m_ov, m_err;

    always #5 clk = ~clk;

    matrix_reg_loader dut (
        .clk(clk), .rst(rst), .keycode(keycode), .store_dig(store_dig),
        .enter(enter), .write_en(write_en), .dest_sel(dest_sel),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .op_req(op_req),
        .op_ack(op_ack), .elem_idx(elem_idx), .stage_full(stage_full),
        .err(err), .mat_a(mat_a), .mat_b(mat_b), .op_valid(op_valid),
        .reg_valid(reg_valid)
    );

    function automatic logic [80:0] pack_stg();
        logic [80:0] v = '0;
        foreach (m_stg[i]) v[9*i +: 9] = 9'(m_stg[i]);
        return v;
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit lerr = 0, ierr = 0;
        if (rst) begin
            m_stg.delete(); m_commit_pend = 0; m_dest = 0;
            for (int i = 0; i < 4; i++) m_bank[i] = '0;
            m_valid = 0; m_a = '0; m_b = '0; m_ov = 0; m_err = 0;
            return;
        end
        if (!m_ov) begin
            if (op_req) begin
                if (m_valid[src_a_sel] && m_valid[src_b_sel]) begin
                    m_a = m_bank[src_a_sel]; m_b = m_bank[src_b_sel]; m_ov = 1;
                end else ierr = 1;
            end
        end else if (op_ack) m_ov = 0;
        if (m_commit_pend) begin
            m_bank[m_dest] = pack_stg();
            m_valid[m_dest] = 1;
            m_stg.delete();
            m_commit_pend = 0;
        end else if (m_stg.size() == 9) begin
            if (store_dig) lerr = 1;
            if (enter && write_en) begin m_dest = dest_sel; m_commit_pend = 1; end
        end else begin
            if (enter && write_en) begin lerr = 1; m_stg.delete(); end
            else if (store_dig) m_stg.push_back(int'(keycode));
        end
        m_err = lerr | ierr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        store_dig = 0; enter = 0; write_en = 0; op_req = 0; op_ack = 0;
    endtask

    task automatic store(input logic [8:0] k);
        keycode = k; store_dig = 1; tick(); store_dig = 0;
    endtask

    task automatic commit_to(input logic [1:0] d);
        enter = 1; write_en = 1; dest_sel = d; tick(); enter = 0; write_en = 0;
        tick();
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); keycode = 0; dest_sel = 0; src_a_sel = 0; src_b_sel = 0;
        tick(); tick(); rst = 0;
        checks++;
        if ({elem_idx, stage_full, err, op_valid, reg_valid} !== 11'd0 || mat_a !== '0 || mat_b !== '0) begin
            errors++;
            $display("FAIL reset_outputs: idx=%0d full=%b err=%b ov=%b rv=%b, required all zero",
                     elem_idx, stage_full, err, op_valid, reg_valid);
        end
    endtask

    task automatic test_full_commit();
        for (int i = 1; i <= 9; i++) store(9'(i));
        checks++;
        if (stage_full !== 1'b1 || elem_idx !== 4'd9) begin
            errors++; $display("FAIL full_after_9: full=%b idx=%0d, required 1/9", stage_full, elem_idx);
        end
        commit_to(2);
        checks++;
        if (reg_valid !== 4'b0100 || elem_idx !== 4'd0 || stage_full !== 1'b0) begin
            errors++; $display("FAIL commit_slot2: rv=%b idx=%0d, required 0100/0", reg_valid, elem_idx);
        end
        src_a_sel = 2; src_b_sel = 2; op_req = 1; tick(); op_req = 0;
        checks++;
        if (op_valid !== 1'b1 || mat_a[8:0] !== 9'd1 || mat_a[80:72] !== 9'd9 || mat_b !== mat_a || mat_a !== m_a) begin
            errors++; $display("FAIL bank2_content: ov=%b a=%h b=%h, required a[8:0]=1 a[80:72]=9 a=%h", op_valid, mat_a, mat_b, m_a);
        end
        op_ack = 1; tick(); op_ack = 0;
    endtask

    task automatic test_abort();
        logic [3:0] rv = reg_valid;
        for (int i = 0; i < 4; i++) store(9'($urandom));
        enter = 1; write_en = 1; tick(); enter = 0; write_en = 0;
        checks++;
        if (err !== 1'b1 || elem_idx !== 4'd0 || reg_valid !== rv) begin
            errors++; $display("FAIL abort_err: err=%b idx=%0d rv=%b, required 1/0/%b", err, elem_idx, reg_valid, rv);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL abort_err_width: err=%b, required 0", err); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) store(9'(16 + i));
        store(9'h1FF);
        checks++;
        if (err !== 1'b1 || elem_idx !== 4'd9) begin
            errors++; $display("FAIL overflow_err: err=%b idx=%0d, required 1/9", err, elem_idx);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL overflow_err_width: err=%b, required 0", err); end
        commit_to(1);
        src_a_sel = 1; src_b_sel = 1; op_req = 1; tick(); op_req = 0;
        checks++;
        if (mat_a[80:72] !== 9'h018 || mat_a[8:0] !== 9'h010) begin
            errors++; $display("FAIL overflow_elem8: a[80:72]=%h a[8:0]=%h, required 018/010", mat_a[80:72], mat_a[8:0]);
        end
        op_ack = 1; tick(); op_ack = 0;
    endtask

    task automatic test_issue_hold();
        logic [80:0] ea, eb;
        for (int i = 0; i < 9; i++) store(9'($urandom));
        commit_to(0);
        ea = m_bank[0]; eb = m_bank[1];
        src_a_sel = 0; src_b_sel = 1; op_req = 1; tick();
        checks++;
        if (op_valid !== 1'b1 || mat_a !== ea || mat_b !== eb) begin
            errors++; $display("FAIL issue_0_1: ov=%b a=%h b=%h, required 1 a=%h b=%h", op_valid, mat_a, mat_b, ea, eb);
        end
        for (int c = 0; c < 5; c++) begin
            src_a_sel = 2'($urandom); src_b_sel = 2'($urandom); tick();
            checks++;
            if (op_valid !== 1'b1 || mat_a !== ea || mat_b !== eb) begin
                errors++; $display("FAIL issue_hold c%0d: ov=%b a=%h b=%h, required held", c, op_valid, mat_a, mat_b);
            end
        end
        op_req = 0; op_ack = 1; tick(); op_ack = 0;
        checks++;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL ack_clear: ov=%b, required 0", op_valid); end
    endtask

    task automatic test_invalid_src();
        src_a_sel = 0; src_b_sel = 3; op_req = 1; tick(); op_req = 0;
        checks++;
        if (err !== 1'b1 || op_valid !== 1'b0) begin
            errors++; $display("FAIL invalid_src: err=%b ov=%b, required 1/0", err, op_valid);
        end
        tick();
        checks++;
        if (err !== 1'b0 || op_valid !== 1'b0) begin
            errors++; $display("FAIL invalid_src_after: err=%b ov=%b, required 0/0", err, op_valid);
        end
    endtask

    task automatic test_collision();
        logic [80:0] old0 = m_bank[0];
        logic [80:0] new0;
        for (int i = 0; i < 9; i++) store(9'($urandom));
        new0 = pack_stg();
        enter = 1; write_en = 1; dest_sel = 0; tick(); enter = 0; write_en = 0;
        src_a_sel = 0; src_b_sel = 0; op_req = 1; tick(); op_req = 0;
        checks++;
        if (mat_a !== old0 || mat_b !== old0) begin
            errors++; $display("FAIL collision_old: a=%h, required %h", mat_a, old0);
        end
        op_ack = 1; tick(); op_ack = 0;
        op_req = 1; tick(); op_req = 0;
        checks++;
        if (mat_a !== new0) begin
            errors++; $display("FAIL collision_new: a=%h, required %h", mat_a, new0);
        end
        op_ack = 1; tick(); op_ack = 0;
    endtask

    task automatic test_reset_mid();
        src_a_sel = 0; src_b_sel = 1; op_req = 1; tick(); op_req = 0;
        for (int i = 0; i < 5; i++) store(9'($urandom));
        rst = 1; tick(); rst = 0;
        checks++;
        if ({elem_idx, stage_full, err, op_valid, reg_valid} !== 11'd0 || mat_a !== '0 || mat_b !== '0) begin
            errors++; $display("FAIL reset_mid: idx=%0d full=%b err=%b ov=%b rv=%b, required all zero",
                               elem_idx, stage_full, err, op_valid, reg_valid);
        end
        store(9'h055);
        checks++;
        if (elem_idx !== 4'd1 || err !== 1'b0) begin
            errors++; $display("FAIL reset_mid_collect: idx=%0d err=%b, required 1/0", elem_idx, err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            keycode   = 9'($urandom);
            store_dig = ($urandom_range(0, 9) < 5);
            enter     = ($urandom_range(0, 9) < 2);
            write_en  = ($urandom_range(0, 9) < 7);
            dest_sel  = 2'($urandom);
            src_a_sel = 2'($urandom);
            src_b_sel = 2'($urandom);
            op_req    = ($urandom_range(0, 9) < 3);
            op_ack    = ($urandom_range(0, 9) < 3);
            tick();
            checks++;
            if (elem_idx !== 4'(m_stg.size()) || stage_full !== (m_stg.size() == 9) || err !== m_err ||
                op_valid !== m_ov || reg_valid !== m_valid || mat_a !== m_a || mat_b !== m_b) begin
                errors++;
                $display("FAIL random c%0d: idx=%0d full=%b err=%b ov=%b rv=%b, required idx=%0d err=%b ov=%b rv=%b",
                         c, elem_idx, stage_full, err, op_valid, reg_valid, m_stg.size(), m_err, m_ov, m_valid);
            end
        end
        rst = 0; idle();
    endtask

    initial begin
        test_reset();
        test_full_commit();
        test_abort();
        test_overflow();
        test_issue_hold();
        test_invalid_src();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
